apb_timer_slave: RTL

//  APB3 completer: memory-mapped down-counter timer behind the APB slave-select mux on the TIMER port.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_slave_if.sv | 83 ++++++++
 rtl/apb_timer_slave.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB timer completer: register offsets, CTRL bit
// positions and the completer FSM state encoding.
package apb_pkg;

    localparam int unsigned REG_CTRL     = 32'h00;
    localparam int unsigned REG_LOAD     = 32'h04;
    localparam int unsigned REG_COUNT    = 32'h08;
    localparam int unsigned REG_STATUS   = 32'h0C;
    localparam int unsigned REG_PRESCALE = 32'h10;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IE          = 2;
    localparam int STATUS_EXP       = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slave_if.sv
// APB3 completer front end: SETUP/ACCESS tracking, programmable wait states,
// and single-cycle wr/rd strobes toward the register file.
module apb_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic                  o_write,
    output logic [ADDR_WIDTH-3:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_err
);

    apb_state_e r_state, w_state_nxt;
    logic [3:0] r_wait, w_wait_nxt;
    logic       w_done;
    logic       w_unused;

    // Byte lanes within a word carry no meaning for this block.
    assign w_unused = ^i_paddr[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt = ACCESS;
                    w_wait_nxt  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                // Losing PSEL mid-transfer abandons it without a commit.
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 4'd0;
                end else if (r_wait != 4'd0) begin
                    w_wait_nxt = r_wait - 4'd1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_pready  = w_done;
    assign o_pslverr = w_done & i_err;
    assign o_prdata  = (w_done && !i_err) ? i_rdata : '0;
    assign o_wr_en   = w_done & i_pwrite;
    assign o_rd_en   = w_done & ~i_pwrite;
    assign o_write   = i_pwrite;
    assign o_addr    = i_paddr[ADDR_WIDTH-1:2];
    assign o_wdata   = i_pwdata;

endmodule

// File: rtl/apb_timer_slave.sv
// APB3 down-counter timer: CTRL/LOAD/COUNT/STATUS registers and a level IRQ.
// Define TIMER_PRESCALER_EN to add the PRESCALE register at offset 0x10.
module apb_timer_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  IRQ
);

    localparam int OW = ADDR_WIDTH - 2;

    logic                  w_wr_en, w_rd_en, w_write, w_err;
    logic [OW-1:0]         w_off;
    logic [DATA_WIDTH-1:0] w_wdata, w_rdata, w_psc_rdata;
    logic                  w_sel_ctrl, w_sel_load, w_sel_count, w_sel_status, w_sel_psc;
    logic                  w_ctrl_wr, w_load_wr, w_status_wr, w_start_wr;
    logic                  w_tick, w_expire;

    logic                  r_en, r_ar, r_ie, r_exp, r_irq, r_start;
    logic [DATA_WIDTH-1:0] r_load, r_count;

    apb_slave_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .WAIT_STATES(WAIT_STATES)
    ) u_if (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETn),
        .i_psel   (PSEL),
        .i_penable(PENABLE),
        .i_pwrite (PWRITE),
        .i_paddr  (PADDR),
        .i_pwdata (PWDATA),
        .o_prdata (PRDATA),
        .o_pready (PREADY),
        .o_pslverr(PSLVERR),
        .o_wr_en  (w_wr_en),
        .o_rd_en  (w_rd_en),
        .o_write  (w_write),
        .o_addr   (w_off),
        .o_wdata  (w_wdata),
        .i_rdata  (w_rdata),
        .i_err    (w_err)
    );

    assign w_sel_ctrl   = (w_off == OW'(REG_CTRL >> 2));
    assign w_sel_load   = (w_off == OW'(REG_LOAD >> 2));
    assign w_sel_count  = (w_off == OW'(REG_COUNT >> 2));
    assign w_sel_status = (w_off == OW'(REG_STATUS >> 2));

    assign w_err = ~(w_sel_ctrl | w_sel_load | w_sel_count | w_sel_status | w_sel_psc)
                 | (w_write & w_sel_count);

    assign w_ctrl_wr   = w_wr_en & w_sel_ctrl;
    assign w_load_wr   = w_wr_en & w_sel_load;
    assign w_status_wr = w_wr_en & w_sel_status;
    assign w_start_wr  = w_ctrl_wr & w_wdata[CTRL_EN] & ~r_en;

`ifdef TIMER_PRESCALER_EN
    logic [15:0] r_prescale, r_pcnt;
    logic        w_psc_wr;

    assign w_sel_psc   = (w_off == OW'(REG_PRESCALE >> 2));
    assign w_psc_wr    = w_wr_en & w_sel_psc;
    assign w_tick      = (r_pcnt == r_prescale);
    assign w_psc_rdata = {{(DATA_WIDTH-16){1'b0}}, r_prescale};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prescale <= 16'd0;
            r_pcnt     <= 16'd0;
        end else if (w_psc_wr) begin
            r_prescale <= w_wdata[15:0];
            r_pcnt     <= 16'd0;
        end else if (w_start_wr) begin
            r_pcnt <= 16'd0;
        end else if (r_en) begin
            r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
        end
    end
`else
    assign w_sel_psc   = 1'b0;
    assign w_tick      = 1'b1;
    assign w_psc_rdata = '0;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_rd_en) begin
            if (w_sel_ctrl) begin
                w_rdata[CTRL_EN]          = r_en;
                w_rdata[CTRL_AUTO_RELOAD] = r_ar;
                w_rdata[CTRL_IE]          = r_ie;
            end else if (w_sel_load) begin
                w_rdata = r_load;
            end else if (w_sel_count) begin
                w_rdata = r_count;
            end else if (w_sel_status) begin
                w_rdata[STATUS_EXP] = r_exp;
            end else if (w_sel_psc) begin
                w_rdata = w_psc_rdata;
            end
        end
    end

    // The start cycle only reloads; the first decrement comes a tick later.
    assign w_expire = r_en & w_tick & ~r_start & (r_count == '0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en    <= 1'b0;
            r_ar    <= 1'b0;
            r_ie    <= 1'b0;
            r_exp   <= 1'b0;
            r_irq   <= 1'b0;
            r_start <= 1'b0;
            r_load  <= '0;
            r_count <= '0;
        end else begin
            r_start <= w_start_wr;
            r_irq   <= r_exp & r_ie;

            if (r_start) begin
                r_count <= r_load;
            end else if (r_en && w_tick) begin
                if (r_count != '0)
                    r_count <= r_count - DATA_WIDTH'(1);
                else if (r_ar)
                    r_count <= r_load;
            end

            if (w_ctrl_wr) begin
                r_en <= w_wdata[CTRL_EN];
                r_ar <= w_wdata[CTRL_AUTO_RELOAD];
                r_ie <= w_wdata[CTRL_IE];
            end else if (w_expire && !r_ar) begin
                r_en <= 1'b0;
            end

            if (w_load_wr)
                r_load <= w_wdata;

            // A fresh expiry outranks a simultaneous W1C.
            r_exp <= w_expire | (r_exp & ~(w_status_wr & w_wdata[STATUS_EXP]));
        end
    end

    assign IRQ = r_irq;

endmodule
